onehot_scan_decoder: RTL

Parametrised, registered binary-to-one-hot decoder with a built-in scan engine. It drives digit/row selects for multiplexed 7-segment and LED-matrix displays on the FPGA boards. It operates in two ways:
- Direct: decodes a host-supplied index.
- Scan: autonomously steps the active line up or down at a prescaled rate.

---
 rtl/onehot_scan_decoder_pkg.sv | 16 +
 rtl/onehot_scan_decoder_if.sv | 28 ++
 rtl/onehot_scan_decoder_prescaler.sv | 31 +++
 rtl/onehot_scan_decoder.sv | 96 +++++++++
 4 files changed

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types and helpers for the one-hot scan decoder and its display drivers.
package onehot_scan_pkg;

   typedef enum logic [1:0] {
      MODE_DIRECT    = 2'b00,
      MODE_SCAN_UP   = 2'b01,
      MODE_SCAN_DOWN = 2'b10,
      MODE_HOLD      = 2'b11
   } mode_e;

   // Counter width able to hold 0..p-1; a single-cycle prescale still needs one bit.
   function automatic int unsigned presc_width(int unsigned p);
      return (p <= 1) ? 1 : $clog2(p);
   endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Host-side control and select-line outputs of the one-hot scan decoder.
interface onehot_scan_decoder_if #(
   parameter int SEL_W = 3
);
   import onehot_scan_pkg::*;

   localparam int OUT_W = 2 ** SEL_W;

   logic             en;
   mode_e            mode;
   logic [SEL_W-1:0] sel;
   logic             load;
   logic [OUT_W-1:0] onehot;
   logic [SEL_W-1:0] index;
   logic             valid;
   logic             wrap;

   modport master (
      output en, mode, sel, load,
      input  onehot, index, valid, wrap
   );

   modport slave (
      input  en, mode, sel, load,
      output onehot, index, valid, wrap
   );

endinterface

// File: rtl/onehot_scan_decoder_prescaler.sv
// Free-running step-rate divider: strobe every PRESCALE cycles of run, restartable via clear.
module scan_prescaler
   import onehot_scan_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic strobe
);

   localparam int unsigned     CNT_W = presc_width(PRESCALE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   assign strobe = run && !clear && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot line select with direct decode and prescaled up/down scanning.
module onehot_scan_decoder
   import onehot_scan_pkg::*;
#(
   parameter int          SEL_W      = 3,
   parameter int unsigned PRESCALE   = 50000,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   onehot_scan_decoder_if.slave  bus
);

   localparam int               OUT_W    = 2 ** SEL_W;
   localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

   mode_e            mode_q;
   logic [SEL_W-1:0] index_q, index_d;
   logic [OUT_W-1:0] onehot_q, onehot_d;
   logic             valid_q, wrap_q, wrap_d;
   logic             scan_mode, mode_chg, load_eff;
   logic             presc_run, presc_clear, strobe;

   always_comb begin
      scan_mode   = (bus.mode == MODE_SCAN_UP) || (bus.mode == MODE_SCAN_DOWN);
      mode_chg    = (bus.mode != mode_q);
      load_eff    = bus.load && (bus.mode != MODE_DIRECT);
      // HOLD neither runs nor clears, so the count stays frozen there.
      presc_clear = !bus.en || (bus.mode == MODE_DIRECT) || load_eff || mode_chg;
      presc_run   = bus.en && scan_mode && !load_eff && !mode_chg;
   end

   scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (presc_run),
      .clear  (presc_clear),
      .strobe (strobe)
   );

   always_comb begin
      index_d = index_q;
      wrap_d  = 1'b0;
      if (bus.en) begin
         unique case (bus.mode)
            MODE_DIRECT: index_d = bus.sel;
            MODE_HOLD: begin
               if (bus.load) index_d = bus.sel;
            end
            MODE_SCAN_UP: begin
               if (bus.load) begin
                  index_d = bus.sel;
               end else if (strobe) begin
                  index_d = index_q + SEL_W'(1);
                  wrap_d  = (index_q == '1);
               end
            end
            MODE_SCAN_DOWN: begin
               if (bus.load) begin
                  index_d = bus.sel;
               end else if (strobe) begin
                  index_d = index_q - SEL_W'(1);
                  wrap_d  = (index_q == '0);
               end
            end
            default: index_d = index_q;
         endcase
      end
      // Decode the next index so onehot and index always agree in the same cycle.
      onehot_d = bus.en ? ((OUT_W'(1) << index_d) ^ INACTIVE) : INACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_q  <= '0;
         onehot_q <= INACTIVE;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
         mode_q   <= MODE_DIRECT;
      end else begin
         index_q  <= index_d;
         onehot_q <= onehot_d;
         valid_q  <= bus.en;
         wrap_q   <= wrap_d;
         mode_q   <= bus.mode;
      end
   end

   assign bus.onehot = onehot_q;
   assign bus.index  = index_q;
   assign bus.valid  = valid_q;
   assign bus.wrap   = wrap_q;

endmodule
